// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Arbitrates a single memory port between an instruction-side reader and a
// data-side reader/writer. One transaction is in flight at a time:
//   IDLE    -> pick a requester, latch its address/data/operation
//   SERVE   -> drive the memory port until m_valid or the wait budget runs out
//   RELEASE -> one quiet cycle so the memory sees idle before the next grant
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   i_re, i_a           instruction read request and address
//   i_rd, i_valid       instruction read block and completion pulse
//   d_re, d_we, d_a     data read/write request and address
//   d_wd                data write word
//   d_rd, d_valid       data read block and completion pulse
//   m_re, m_we          memory read / write enables (SERVE only)
//   m_a, m_wd           memory address / write word (zero outside SERVE)
//   m_rd, m_valid       memory read block and one-cycle completion
//   busy                high whenever the arbiter is not IDLE
//   err                 sticky flag: some transaction timed out
//
// Handshake: a requester raises its request and holds it until it sees its
// own valid pulse. valid is combinational from m_valid during SERVE and lasts
// exactly the one cycle m_valid is high. The read block is passed straight
// through to both sides; each side qualifies it with its own valid.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int BLOCKSIZE = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_re,
    input  logic [31:0]             i_a,
    output logic [BLOCKSIZE*32-1:0] i_rd,
    output logic                    i_valid,
    input  logic                    d_re,
    input  logic                    d_we,
    input  logic [31:0]             d_a,
    input  logic [31:0]             d_wd,
    output logic [BLOCKSIZE*32-1:0] d_rd,
    output logic                    d_valid,
    output logic                    m_re,
    output logic                    m_we,
    output logic [31:0]             m_a,
    output logic [31:0]             m_wd,
    input  logic [BLOCKSIZE*32-1:0] m_rd,
    input  logic                    m_valid,
    output logic                    busy,
    output logic                    err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Wait count at which the current SERVE cycle is the last one allowed;
    // leaving here means the counter has reached TIMEOUT.
    localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic        last_grant, last_grant_nx;  // 0 = instruction, 1 = data
    logic        gnt_data, gnt_data_nx;      // side owning the current transaction
    logic        op_we, op_we_nx;            // latched operation: 1 = write
    logic [31:0] addr, addr_nx;
    logic [31:0] wdata, wdata_nx;
    logic [4:0]  wait_cnt, wait_cnt_nx;
    logic        err_q, err_nx;

    logic d_req;
    logic sel_data;
    logic serving;

    assign d_req   = d_re | d_we;
    // Data wins when it is the only requester, or when both request and the
    // instruction side had the previous grant.
    assign sel_data = d_req & (~i_re | ~last_grant);
    assign serving = (state == SERVE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            gnt_data   <= 1'b0;
            op_we      <= 1'b0;
            addr       <= 32'd0;
            wdata      <= 32'd0;
            wait_cnt   <= 5'd0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            gnt_data   <= gnt_data_nx;
            op_we      <= op_we_nx;
            addr       <= addr_nx;
            wdata      <= wdata_nx;
            wait_cnt   <= wait_cnt_nx;
            err_q      <= err_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        gnt_data_nx   = gnt_data;
        op_we_nx      = op_we;
        addr_nx       = addr;
        wdata_nx      = wdata;
        wait_cnt_nx   = wait_cnt;
        err_nx        = err_q;

        case (state)
            IDLE: begin
                if (i_re | d_req) begin
                    state_nx      = SERVE;
                    gnt_data_nx   = sel_data;
                    last_grant_nx = sel_data;
                    // A data request with both d_re and d_we is a write.
                    op_we_nx      = sel_data & d_we;
                    addr_nx       = sel_data ? d_a : i_a;
                    wdata_nx      = sel_data ? d_wd : 32'd0;
                    wait_cnt_nx   = 5'd0;
                end
            end
            SERVE: begin
                // Request inputs are deliberately not looked at here.
                if (m_valid) begin
                    state_nx = RELEASE;
                end else begin
                    wait_cnt_nx = wait_cnt + 5'd1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nx = RELEASE;
                        err_nx   = 1'b1;
                    end
                end
            end
            RELEASE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // The memory port is driven only while SERVE; everything is zero otherwise,
    // including while reset holds state at IDLE.
    assign m_re = serving & ~op_we;
    assign m_we = serving & op_we;
    assign m_a  = serving ? addr  : 32'd0;
    assign m_wd = serving ? wdata : 32'd0;

    // m_valid outside SERVE never reaches a requester.
    assign i_valid = serving & m_valid & ~gnt_data;
    assign d_valid = serving & m_valid & gnt_data;

    assign i_rd = m_rd;
    assign d_rd = m_rd;

    assign busy = (state != IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Expected transactions (side, op, address,
// write word) are queued in the order the bench expects them to be granted;
// the memory responder pops the head when the granted side's valid appears.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int BS = 4;
    localparam int W  = BS * 32;

    // clock / reset
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          i_re    = 1'b0;
    logic [31:0]   i_a     = 32'd0;
    logic [W-1:0]  i_rd;
    logic          i_valid;
    logic          d_re    = 1'b0;
    logic          d_we    = 1'b0;
    logic [31:0]   d_a     = 32'd0;
    logic [31:0]   d_wd    = 32'd0;
    logic [W-1:0]  d_rd;
    logic          d_valid;
    logic          m_re;
    logic          m_we;
    logic [31:0]   m_a;
    logic [31:0]   m_wd;
    logic [W-1:0]  m_rd    = '0;
    logic          m_valid = 1'b0;
    logic          busy;
    logic          err;

    mem_arbiter #(.BLOCKSIZE(BS), .TIMEOUT(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_re    (i_re),
        .i_a     (i_a),
        .i_rd    (i_rd),
        .i_valid (i_valid),
        .d_re    (d_re),
        .d_we    (d_we),
        .d_a     (d_a),
        .d_wd    (d_wd),
        .d_rd    (d_rd),
        .d_valid (d_valid),
        .m_re    (m_re),
        .m_we    (m_we),
        .m_a     (m_a),
        .m_wd    (m_wd),
        .m_rd    (m_rd),
        .m_valid (m_valid),
        .busy    (busy),
        .err     (err)
    );

    // scoreboard: {side(1=data), we, addr[31:0], wd[31:0]}
    logic [65:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int i_cnt  = 0;
    int d_cnt  = 0;

    function automatic logic [65:0] txn(input logic side, input logic we,
                                        input logic [31:0] a, input logic [31:0] wd);
        return {side, we, a, wd};
    endfunction

    function automatic logic [W-1:0] rand_block();
        return W'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic serve_checks(input logic [65:0] e);
        check("serve_m_a", W'(m_a), W'(e[63:32]));
        check("serve_m_we", W'(m_we), W'(e[64]));
        check("serve_m_re", W'(m_re), W'(!e[64]));
        if (e[64]) check("serve_m_wd", W'(m_wd), W'(e[31:0]));
        check("serve_busy", W'(busy), W'(1'b1));
        check("serve_no_valid", W'({i_valid, d_valid}), W'(2'b00));
    endtask

    // Memory responder: waits for the grant, holds SERVE for 1+lat cycles,
    // pulses m_valid with a fresh block, then checks RELEASE and IDLE.
    // Returns at the negedge of the IDLE cycle; busy_n counts busy cycles seen.
    task automatic mem_respond(input int lat, input bit drop_i, input bit drop_d,
                               output int busy_n);
        logic [65:0]  e;
        logic [W-1:0] data;
        bit           found;
        found  = 0;
        busy_n = 0;
        check("txn_pending", W'(exp_q.size() != 0), W'(1'b1));
        e = (exp_q.size() != 0) ? exp_q[0] : '0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (m_re || m_we) found = 1;
        end
        check("grant_seen", W'(found), W'(1'b1));
        if (!found) return;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                post_edge();
                @(negedge clk);
            end
            if (busy) busy_n++;
            serve_checks(e);
        end
        post_edge();
        data    = rand_block();
        m_valid = 1'b1;
        m_rd    = data;
        @(negedge clk);
        if (busy) busy_n++;
        check("i_valid", W'(i_valid), W'(!e[65]));
        check("d_valid", W'(d_valid), W'(e[65]));
        check("valid_m_a", W'(m_a), W'(e[63:32]));
        check("valid_m_re", W'(m_re), W'(!e[64]));
        check("i_rd", i_rd, data);
        check("d_rd", d_rd, data);
        if (i_valid) i_cnt++;
        if (d_valid) d_cnt++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        post_edge();
        m_valid = 1'b0;
        if (drop_i) i_re = 1'b0;
        if (drop_d) begin
            d_re = 1'b0;
            d_we = 1'b0;
        end
        @(negedge clk);
        if (busy) busy_n++;
        check("release_busy", W'(busy), W'(1'b1));
        check("release_port", W'({m_re, m_we, m_a, m_wd}), W'(0));
        check("release_no_valid", W'({i_valid, d_valid}), W'(2'b00));
        post_edge();
        @(negedge clk);
        check("idle_after_release", W'(busy), W'(1'b0));
    endtask

    initial begin
        int bn;
        int ic0;
        int dc0;
        int cnt;
        bit done;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", W'(busy), W'(1'b0));
        check("rst_port", W'({m_re, m_we, m_a, m_wd}), W'(0));
        check("rst_valid", W'({i_valid, d_valid}), W'(2'b00));
        check("rst_err", W'(err), W'(1'b0));
        post_edge();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", W'(busy), W'(1'b0));

        // ---- single instruction read, 5 busy cycles ----
        post_edge();
        i_re = 1'b1;
        i_a  = 32'h100;
        exp_q.push_back(txn(1'b0, 1'b0, 32'h100, 32'h0));
        mem_respond(2, 1, 0, bn);
        check("i_read_busy_cycles", W'(bn), W'(5));

        // ---- stray m_valid in IDLE is ignored ----
        post_edge();
        m_valid = 1'b1;
        @(negedge clk);
        check("idle_mvalid_no_valid", W'({i_valid, d_valid}), W'(2'b00));
        check("idle_mvalid_busy", W'(busy), W'(1'b0));
        post_edge();
        m_valid = 1'b0;
        @(negedge clk);
        check("idle_mvalid_stay_idle", W'(busy), W'(1'b0));

        // ---- simultaneous requests after reset: data first ----
        post_edge();
        reset = 1'b1;
        post_edge();
        post_edge();
        reset = 1'b0;
        i_re = 1'b1;
        i_a  = 32'h40;
        d_re = 1'b1;
        d_a  = 32'h80;
        d_wd = 32'h0;
        exp_q.push_back(txn(1'b1, 1'b0, 32'h80, 32'h0));
        exp_q.push_back(txn(1'b0, 1'b0, 32'h40, 32'h0));
        ic0 = i_cnt;
        dc0 = d_cnt;
        mem_respond(1, 0, 1, bn);
        mem_respond(2, 1, 0, bn);
        check("simul_d_pulses", W'(d_cnt - dc0), W'(1));
        check("simul_i_pulses", W'(i_cnt - ic0), W'(1));

        // ---- round robin with both sides continuously requesting ----
        post_edge();
        i_re = 1'b1;
        i_a  = 32'h1000;
        d_re = 1'b1;
        d_a  = 32'h2000;
        exp_q.push_back(txn(1'b1, 1'b0, 32'h2000, 32'h0));
        exp_q.push_back(txn(1'b0, 1'b0, 32'h1000, 32'h0));
        exp_q.push_back(txn(1'b1, 1'b0, 32'h2000, 32'h0));
        exp_q.push_back(txn(1'b0, 1'b0, 32'h1000, 32'h0));
        mem_respond($urandom_range(0, 3), 0, 0, bn);
        mem_respond($urandom_range(0, 3), 0, 0, bn);
        mem_respond($urandom_range(0, 3), 0, 1, bn);
        mem_respond($urandom_range(0, 3), 1, 0, bn);

        // ---- write wins over read on the data side ----
        post_edge();
        d_re = 1'b1;
        d_we = 1'b1;
        d_a  = 32'h20;
        d_wd = 32'hDEADBEEF;
        exp_q.push_back(txn(1'b1, 1'b1, 32'h20, 32'hDEADBEEF));
        dc0 = d_cnt;
        mem_respond(1, 0, 1, bn);
        check("write_d_pulses", W'(d_cnt - dc0), W'(1));
        d_wd = 32'h0;

        // ---- timeout: instruction read with no m_valid ----
        post_edge();
        check("pre_timeout_err", W'(err), W'(1'b0));
        i_re = 1'b1;
        i_a  = 32'h300;
        ic0  = i_cnt;
        cnt  = 0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (m_re) begin
                cnt++;
                check("timeout_no_valid", W'({i_valid, d_valid}), W'(2'b00));
            end else if (busy) begin
                done = 1;
            end
        end
        check("timeout_release", W'(done), W'(1'b1));
        check("timeout_serve_cycles", W'(cnt), W'(16));
        check("timeout_err_set", W'(err), W'(1'b1));
        i_re = 1'b0;
        post_edge();
        @(negedge clk);
        check("timeout_back_idle", W'(busy), W'(1'b0));
        check("timeout_err_sticky", W'(err), W'(1'b1));
        post_edge();
        d_re = 1'b1;
        d_we = 1'b0;
        d_a  = 32'h500;
        exp_q.push_back(txn(1'b1, 1'b0, 32'h500, 32'h0));
        mem_respond(3, 0, 1, bn);
        check("timeout_err_kept", W'(err), W'(1'b1));
        check("timeout_i_pulses", W'(i_cnt - ic0), W'(0));

        // ---- reset one cycle into SERVE ----
        post_edge();
        i_re = 1'b1;
        i_a  = 32'h600;
        post_edge();
        post_edge();
        check("pre_reset_m_re", W'(m_re), W'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        check("reset_m_re_drop", W'({m_re, m_we}), W'(2'b00));
        check("reset_busy", W'(busy), W'(1'b0));
        check("reset_no_valid", W'({i_valid, d_valid}), W'(2'b00));
        check("reset_err_clear", W'(err), W'(1'b0));
        check("reset_m_a", W'(m_a), W'(0));
        i_re = 1'b0;
        post_edge();
        post_edge();
        reset = 1'b0;
        @(negedge clk);
        check("after_reset_idle", W'(busy), W'(1'b0));

        // ---- first simultaneous request after this reset goes to data ----
        post_edge();
        i_re = 1'b1;
        i_a  = 32'h44;
        d_re = 1'b1;
        d_a  = 32'h88;
        exp_q.push_back(txn(1'b1, 1'b0, 32'h88, 32'h0));
        exp_q.push_back(txn(1'b0, 1'b0, 32'h44, 32'h0));
        mem_respond(0, 0, 1, bn);
        mem_respond(0, 1, 0, bn);

        check("queue_drained", W'(exp_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
